// File: rtl/fpu_op_sequencer.sv
// Registered request/response wrapper around the combinational FPU core.
// Holds core inputs for SETTLE cycles, then captures the result and IEEE flags.
module fpu_op_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [63:0]      req_fpa,
  input  logic [63:0]      req_fpb,
  input  logic             req_db,
  input  logic             req_normal,
  input  logic [1:0]       req_rm,
  output logic [63:0]      m_fpa,
  output logic [63:0]      m_fpb,
  output logic             m_db,
  output logic             m_normal,
  output logic             m_sub,
  output logic             m_fdiv,
  output logic [1:0]       m_rm,
  input  logic [63:0]      fp_mul_out,
  input  logic [63:0]      fp_add_out,
  input  logic [4:0]       IEEp_mul,
  input  logic [4:0]       IEEp_add,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [4:0]       sticky_flags,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [3:0] LoadVal = 4'(SETTLE - 1);

  state_e     r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_mul_sel;
  logic       r_rdy_en;
  logic       w_accept, w_capture, w_done;
  logic [63:0] w_sel_result;
  logic [4:0]  w_sel_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (req_valid && r_rdy_en) w_state_nxt = StSettle;
      StSettle: if (r_cnt == 4'd0)         w_state_nxt = StResp;
      StResp:   if (rsp_ready)             w_state_nxt = StIdle;
      default:                             w_state_nxt = StIdle;
    endcase
  end

  // Handshake qualifiers decode registered state only.
  always_comb begin
    req_ready = r_rdy_en && (r_state == StIdle);
    busy      = (r_state != StIdle);
    rsp_valid = (r_state == StResp);
    w_accept  = req_ready && req_valid;
    w_capture = (r_state == StSettle) && (r_cnt == 4'd0);
    w_done    = (r_state == StResp) && rsp_ready;
  end

  assign w_sel_result = r_mul_sel ? fp_mul_out : fp_add_out;
  assign w_sel_flags  = r_mul_sel ? IEEp_mul   : IEEp_add;

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fpa     <= '0;
      m_fpb     <= '0;
      m_db      <= 1'b0;
      m_normal  <= 1'b0;
      m_sub     <= 1'b0;
      m_fdiv    <= 1'b0;
      m_rm      <= '0;
      r_mul_sel <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      m_fpa     <= req_fpa;
      m_fpb     <= req_fpb;
      m_db      <= req_db;
      m_normal  <= req_normal;
      m_sub     <= (req_op == 2'b01);
      m_fdiv    <= (req_op == 2'b11);
      m_rm      <= req_rm;
      r_mul_sel <= req_op[1];
      r_cnt     <= LoadVal;
    end else if ((r_state == StSettle) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (w_capture) begin
      rsp_result <= w_sel_result;
      rsp_flags  <= w_sel_flags;
    end
  end

  // A clear coinciding with a capture keeps the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (w_capture) begin
      sticky_flags <= flag_clr ? w_sel_flags : (sticky_flags | w_sel_flags);
    end else if (flag_clr) begin
      sticky_flags <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ops_done <= '0;
    else if (w_done) ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
